// File: rtl/operand_mux_arbiter.sv
// Two-channel round-robin arbiter driving a shared 2:1 operand mux into a
// single-entry output buffer with a valid/ready consumer handshake.
module operand_mux_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             prio;
  logic             last_sel;
  logic             can_accept;
  logic             grant_a;
  logic             grant_b;
  logic [WIDTH-1:0] mux_out;

  // rst_n gates acceptance so no ready is raised while reset is held.
  always_comb begin
    can_accept = rst_n && ((state == EMPTY) || out_ready);
    grant_a    = can_accept && a_valid && (!b_valid || !prio);
    grant_b    = can_accept && b_valid && (!a_valid ||  prio);
    if (grant_b)      sel = 1'b1;
    else if (grant_a) sel = 1'b0;
    else              sel = last_sel;
    mux_out = sel ? b_data : a_data;
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      out_data    <= '0;
      prio        <= 1'b0;
      last_sel    <= 1'b0;
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else if (grant_a || grant_b) begin
      out_data <= mux_out;
      state    <= FULL;
      prio     <= ~sel;
      last_sel <= sel;
      if (grant_a && (grant_cnt_a != '1)) grant_cnt_a <= grant_cnt_a + CNT_W'(1);
      if (grant_b && (grant_cnt_b != '1)) grant_cnt_b <= grant_cnt_b + CNT_W'(1);
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule
